joypad_target: RTL
==================

JOYPAD_TARGET -- requirements
Module: joypad_target

Interface
REQ-001 The block SHALL have parameter ADDR, default 7'h20, giving the 7-bit target address it answers to.
REQ-002 The block SHALL have parameter ID, default 8'hA5, giving the constant value of register 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change only on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port scl_in, input, 1 bit: serial clock from the initiator, asynchronous to clk.
REQ-006 Port sda_in, input, 1 bit: serial data line as sensed, asynchronous to clk.
REQ-007 Port sda_out, output, 1 bit: open-drain data drive; 0 pulls the line low, 1 releases it.
REQ-008 Port buttons_n, input, 8 bits: button levels, active-low, asynchronous; bit 7 = A, 6 = B, 5 = Select, 4 = Start, 3 = Up, 2 = Down, 1 = Left, 0 = Right.
REQ-009 Port busy, output, 1 bit: high from a START condition until the next STOP condition.

Function
REQ-010 scl_in, sda_in and buttons_n SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-011 START SHALL be detected when synchronized SDA falls while synchronized SCL is high; STOP when SDA rises while SCL is high.
REQ-012 Data bits SHALL be sampled on the synchronized SCL rising edge; sda_out SHALL change only on the cycle after a synchronized SCL falling edge.
REQ-013 The FSM SHALL have states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE and RD_ACK.
REQ-014 START, including a repeated START, SHALL enter ADDR from any state; STOP SHALL enter IDLE from any state.
REQ-015 ADDR SHALL shift in 8 bits MSB first. On a match of the top 7 bits with ADDR the FSM SHALL go to ADDR_ACK; on a mismatch it SHALL go to IDLE and keep sda_out = 1.
REQ-016 ADDR_ACK SHALL drive sda_out = 0 for exactly one SCL high period. It SHALL then go to RD_BYTE if the R/W bit is 1, or to WR_BYTE if it is 0.
REQ-017 The 2-bit register pointer SHALL be loaded from bits [1:0] of the first byte written in WR_BYTE; every byte is acknowledged in WR_ACK, and further written bytes SHALL be ignored.
REQ-018 On entry to RD_BYTE, the selected register SHALL be copied into an 8-bit shift register and shifted out MSB first.
REQ-019 Register 0 SHALL read ~buttons_n as sampled on entry to RD_BYTE (1 = pressed).
REQ-020 Register 1 SHALL read the sticky press mask: bit i is set on any synchronized 1->0 edge of buttons_n[i].
REQ-021 The sticky press mask SHALL clear when its byte is loaded for transmission; an edge in that same cycle SHALL remain set.
REQ-022 Register 2 SHALL read ID; register 3 SHALL read 8'hFF.
REQ-023 After each read byte the pointer SHALL increment modulo 4, so 3 wraps to 0.
REQ-024 In RD_ACK, the target SHALL release SDA and sample the initiator's bit on SCL rise. ACK (0) SHALL go to RD_BYTE; NACK (1) SHALL go to IDLE with sda_out = 1 until the next START.
REQ-025 busy SHALL follow REQ-009, including for address mismatches.

Reset
REQ-026 With rst high at a clk edge: state SHALL be IDLE, sda_out = 1, busy = 0, pointer = 0, press mask = 0, synchronizers = 1. This SHALL hold mid-transfer, and the line SHALL be released the next cycle.
REQ-027 After reset deasserts, a transfer SHALL begin only after a fresh START.

Verification
REQ-028 Write 8'h40 then 8'h00, START, address 8'h41, read 3 bytes with ACK, ACK, NACK, STOP, and buttons_n = 8'h7E -> bytes 8'h81, press mask, 8'hA5; sda_out = 1 after the NACK.
REQ-029 Pointer = 3, read 2 bytes -> 8'hFF then register 0 (wrap).
REQ-030 Address 8'h43 -> no ACK (sda_out stays 1 throughout), busy high until STOP.
REQ-031 Pulse buttons_n[4] low then high with no transfer, then read register 1 -> 8'h10; a second read -> 8'h00.
REQ-032 Assert rst during bit 3 of RD_BYTE -> sda_out = 1 and busy = 0 one cycle later; the next START and address 8'h41 are acknowledged normally.
REQ-033 Repeated START after a write of pointer 2, then address 8'h41 -> reads 8'hA5.

Source files
------------

// File: rtl/joypad_target.sv
// joypad_target: two-wire target exposing an 8-button joypad.
// Registers: 0 = live buttons, 1 = sticky presses, 2 = ID, 3 = 8'hFF.
module joypad_target #(
  parameter logic [6:0] ADDR = 7'h20,
  parameter logic [7:0] ID   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic [7:0] buttons_n,
  output logic       sda_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK
  } state_t;

  logic [1:0] scl_sy, sda_sy;
  logic       scl_q, sda_q;
  logic [7:0] btn_s1, btn_s, btn_q;
  logic [1:0] settle;

  logic       scl, sda;
  logic       rise, fall, armed;
  logic       start_c, stop_c;
  logic [7:0] fell;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] sh, sh_nx;
  logic [1:0] ptr, ptr_nx;
  logic       first, first_nx;
  logic       ack, ack_nx;
  logic       sda_nx, busy_nx;
  logic [7:0] mask, mask_nx;
  logic [7:0] rd_val;
  logic       load;

  // Synchronizers and edge history; start detection waits for them to fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
      btn_s1 <= 8'hFF;
      btn_s  <= 8'hFF;
      btn_q  <= 8'hFF;
      settle <= 2'd0;
    end else begin
      scl_sy <= {scl_sy[0], scl_in};
      sda_sy <= {sda_sy[0], sda_in};
      scl_q  <= scl_sy[1];
      sda_q  <= sda_sy[1];
      btn_s1 <= buttons_n;
      btn_s  <= btn_s1;
      btn_q  <= btn_s;
      if (settle != 2'd3)
        settle <= settle + 2'd1;
    end
  end

  assign scl     = scl_sy[1];
  assign sda     = sda_sy[1];
  assign rise    = scl & ~scl_q;
  assign fall    = ~scl & scl_q;
  assign armed   = (settle == 2'd3);
  assign start_c = armed & scl & scl_q & sda_q & ~sda;
  assign stop_c  = armed & scl & scl_q & ~sda_q & sda;
  assign fell    = btn_q & ~btn_s;

  // Register file read mux, addressed by the pointer.
  always_comb begin
    rd_val = 8'hFF;
    unique case (ptr)
      2'd0:    rd_val = ~btn_s;
      2'd1:    rd_val = mask;
      2'd2:    rd_val = ID;
      default: rd_val = 8'hFF;
    endcase
  end

  // Protocol FSM: next state, shifter, pointer and line drive.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    ptr_nx   = ptr;
    first_nx = first;
    ack_nx   = ack;
    sda_nx   = sda_out;
    busy_nx  = busy;
    load     = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_ADDR: begin
        if (rise) begin
          sh_nx  = {sh[6:0], sda};
          cnt_nx = cnt + 4'd1;
        end else if (fall && cnt == 4'd8) begin
          cnt_nx = 4'd0;
          if (sh[7:1] == ADDR) begin
            state_nx = S_ADDR_ACK;
            sda_nx   = 1'b0;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_ADDR_ACK: begin
        if (fall) begin
          if (sh[0]) begin
            load = 1'b1;
          end else begin
            state_nx = S_WR_BYTE;
            sda_nx   = 1'b1;
            first_nx = 1'b1;
          end
        end
      end
      S_WR_BYTE: begin
        if (rise) begin
          sh_nx  = {sh[6:0], sda};
          cnt_nx = cnt + 4'd1;
        end else if (fall && cnt == 4'd8) begin
          cnt_nx   = 4'd0;
          state_nx = S_WR_ACK;
          sda_nx   = 1'b0;
          if (first) begin
            ptr_nx   = sh[1:0];
            first_nx = 1'b0;
          end
        end
      end
      S_WR_ACK: begin
        if (fall) begin
          state_nx = S_WR_BYTE;
          sda_nx   = 1'b1;
        end
      end
      S_RD_BYTE: begin
        if (rise) begin
          cnt_nx = cnt + 4'd1;
        end else if (fall) begin
          if (cnt == 4'd8) begin
            cnt_nx   = 4'd0;
            state_nx = S_RD_ACK;
            sda_nx   = 1'b1;
            ptr_nx   = ptr + 2'd1;
          end else begin
            sda_nx = sh[6];
            sh_nx  = {sh[6:0], 1'b0};
          end
        end
      end
      S_RD_ACK: begin
        if (rise) begin
          ack_nx = sda;
        end else if (fall) begin
          if (ack) begin
            state_nx = S_IDLE;
            sda_nx   = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (load) begin
      state_nx = S_RD_BYTE;
      sh_nx    = rd_val;
      sda_nx   = rd_val[7];
      cnt_nx   = 4'd0;
    end
    if (start_c) begin
      state_nx = S_ADDR;
      cnt_nx   = 4'd0;
      sda_nx   = 1'b1;
      busy_nx  = 1'b1;
      load     = 1'b0;
    end else if (stop_c) begin
      state_nx = S_IDLE;
      cnt_nx   = 4'd0;
      sda_nx   = 1'b1;
      busy_nx  = 1'b0;
      load     = 1'b0;
    end
    mask_nx = ((load && ptr == 2'd1) ? 8'h00 : mask) | fell;
  end

  // FSM and datapath state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      sh      <= 8'h00;
      ptr     <= 2'd0;
      first   <= 1'b0;
      ack     <= 1'b1;
      sda_out <= 1'b1;
      busy    <= 1'b0;
      mask    <= 8'h00;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      sh      <= sh_nx;
      ptr     <= ptr_nx;
      first   <= first_nx;
      ack     <= ack_nx;
      sda_out <= sda_nx;
      busy    <= busy_nx;
      mask    <= mask_nx;
    end
  end

endmodule
